if_stage: RTL and testbench

Instruction-fetch stage. It owns the PC, issues requests to instruction memory over a valid/ready request channel, and accepts in-order responses. Fetched instructions are buffered in a small queue and presented to the decode stage as instruction/pc/valid. Branch and jump redirects from EX flush the queue and discard in-flight responses.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage_fetch_fifo.sv | 53 +++++
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction-fetch stage.
// Included by the fetch stage, its queue and the imem interface.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave). Responses return in request order.
interface if_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// Small fetch queue holding {pc, instr} entries; head is readable combinationally.
// Flush empties it in one cycle and takes priority over push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [CW-1:0] occupancy,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head      = mem_reg[rd_ptr_reg];
  assign occupancy = count_reg;
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests,
// queues in-order responses for decode and discards responses made stale by redirects.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH        = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ID,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] instruction,
  output logic [31:0] pc_ID,
  output logic        instr_valid
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int OCC_W = $clog2(FQ_DEPTH + 1);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      rsp_pc_reg, rsp_pc_next;
  logic [31:0]      pc_hold_reg;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic [CNT_W-1:0] live;
  logic [OCC_W-1:0] occupancy;
  logic             fq_empty, fq_full;
  logic             issue, req_fire, rsp_fire, push, pop;
  fetch_entry_t     head, push_entry;

  // Only responses that will be kept reserve queue space, so a push always finds room.
  assign live  = outstanding_reg - drop_reg;
  assign issue = !redirect_valid
              && (int'(outstanding_reg) < MAX_OUTSTANDING)
              && (int'(occupancy) + int'(live) < FQ_DEPTH);

  assign imem.imem_req_valid = issue && !reset;
  assign imem.imem_req_addr  = fetch_pc_reg;

  assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_fire   = imem.imem_rsp_valid;
  assign push       = rsp_fire && (drop_reg == '0) && !redirect_valid;
  assign pop        = instr_valid && !stall_ID && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_reg, instr: imem.imem_rsp_data};

  always_comb begin
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    drop_next        = drop_reg;
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_next     = outstanding_next;
      fetch_pc_next = redirect_pc;
      rsp_pc_next   = redirect_pc;
    end else begin
      if (rsp_fire && (drop_reg != '0)) drop_next = drop_reg - 1'b1;
      if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (push)     rsp_pc_next   = rsp_pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      pc_hold_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (!fq_empty) pc_hold_reg <= head.pc;
    end
  end

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (head),
    .occupancy (occupancy),
    .empty     (fq_empty),
    .full      (fq_full)
  );

  assign instr_valid = !fq_empty;
  assign instruction = fq_empty ? NOP_INSTR : head.instr;
  assign pc_ID       = fq_empty ? pc_hold_reg : head.pc;

  push_into_full_queue: assert property (@(posedge clk) disable iff (reset) !(push && fq_full));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order imem model plus a stream-level reference model
// (expected PC sequence from reset/redirect targets) with directed and random scenarios.
module tb_if_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int          MAXO   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_ID;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_ID;
  logic        instr_valid;

  if_stage_if imem ();

  if_stage #(.RESET_PC(RST_PC), .FQ_DEPTH(2), .MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_ID       (stall_ID),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .instruction    (instruction),
    .pc_ID          (pc_ID),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory contents: odd multiplier makes every word address map to a distinct word.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } req_t;

  req_t        mem_q[$];
  int          rsp_pct = 100;
  int          cyc = 0;
  logic [31:0] exp_pc, exp_req, last_acc;
  int          pops = 0, accepts = 0;
  int          err_stream = 0, err_seq = 0, err_hold = 0, err_out = 0, err_stall = 0, err_nop = 0;
  logic [31:0] bad_pc = 0, bad_exp = 0;
  logic        prev_wait = 0, prev_stall_hold = 0;
  logic [31:0] prev_pc = 0, prev_instr = 0, prev_addr = 0;

  function automatic int err_sum();
    return err_stream + err_seq + err_hold + err_out + err_stall + err_nop;
  endfunction

  // Memory: answers the oldest accepted request no earlier than one cycle after accept.
  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_q.size() > 0 && mem_q[0].cyc < cyc && int'($urandom_range(99)) < rsp_pct) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = memf(mem_q[0].addr);
      end else begin
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = $urandom;
      end
    end
  end

  // Reference model: tallies deviations from the expected fetch stream and protocol rules.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        mem_q.delete();
        exp_pc          = RST_PC;
        exp_req         = RST_PC;
        pops            = 0;
        accepts         = 0;
        prev_wait       = 1'b0;
        prev_stall_hold = 1'b0;
      end else begin
        if (!instr_valid && instruction !== NOP_INSTR) err_nop++;
        if (prev_stall_hold && (instr_valid !== 1'b1 || pc_ID !== prev_pc || instruction !== prev_instr))
          err_stall++;
        if (prev_wait && !redirect_valid &&
            (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== prev_addr))
          err_hold++;
        if (redirect_valid && imem.imem_req_valid) err_seq++;
        if (imem.imem_rsp_valid && mem_q.size() > 0) mem_q.delete(0);
        if (imem.imem_req_valid && imem.imem_req_ready) begin
          if (imem.imem_req_addr !== exp_req) err_seq++;
          exp_req = exp_req + 32'd4;
          mem_q.push_back('{imem.imem_req_addr, cyc});
          accepts++;
          last_acc = imem.imem_req_addr;
        end
        if (mem_q.size() > MAXO) err_out++;
        if (redirect_valid) begin
          exp_pc  = redirect_pc;
          exp_req = redirect_pc;
        end else if (instr_valid && !stall_ID) begin
          if (pc_ID !== exp_pc || instruction !== memf(exp_pc)) begin
            if (err_stream == 0) begin
              bad_pc  = pc_ID;
              bad_exp = exp_pc;
            end
            err_stream++;
          end
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        prev_wait       = imem.imem_req_valid && !imem.imem_req_ready && !redirect_valid;
        prev_stall_hold = instr_valid && stall_ID && !redirect_valid;
        prev_pc         = pc_ID;
        prev_instr      = instruction;
        prev_addr       = imem.imem_req_addr;
      end
      cyc++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    stall_ID       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem.imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #3;
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests_run++;
    if (instruction !== NOP_INSTR) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", instruction, NOP_INSTR); end
    tests_run++;
    if (pc_ID !== RST_PC) begin tests_failed++; $display("FAIL reset_pc_ID: got %h want %h", pc_ID, RST_PC); end
    tests_run++;
    if (imem.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", imem.imem_req_valid); end
    tests_run++;
    if (imem.imem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_req_addr: got %h want %h", imem.imem_req_addr, RST_PC); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_first_fetch();
    rsp_pct = 100;
    do_reset();
    #3;
    tests_run++;
    if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL first_req: got valid=%b addr=%h want 1/%h", imem.imem_req_valid, imem.imem_req_addr, RST_PC);
    end
    run_cycles(1);
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early_valid: got %b want 0", instr_valid); end
    run_cycles(1);
    tests_run++;
    if (instr_valid !== 1'b1 || pc_ID !== RST_PC || instruction !== memf(RST_PC)) begin
      tests_failed++;
      $display("FAIL first_instr: got v=%b pc=%h i=%h want 1/%h/%h", instr_valid, pc_ID, instruction, RST_PC, memf(RST_PC));
    end
    run_cycles(12);
    tests_run++;
    if (pops < 6 || err_sum() != 0) begin
      tests_failed++;
      $display("FAIL first_stream: got pops=%0d errs=%0d (pc %h exp %h) want >=6/0", pops, err_sum(), bad_pc, bad_exp);
    end
    $display("[TB] test_first_fetch done, %0d instructions delivered", pops);
  endtask

  task automatic test_stall();
    logic [31:0] rec_pc, rec_instr;
    int pops_before;
    rec_pc = '0;
    rec_instr = '0;
    rsp_pct = 100;
    do_reset();
    run_cycles(6);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      stall_ID = 1'b1;
      #3;
      if (k == 2) begin
        rec_pc    = pc_ID;
        rec_instr = instruction;
      end
      if (k >= 3) begin
        tests_run++;
        if (imem.imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL stall_full: got req_valid=%b instr_valid=%b want 0/1", imem.imem_req_valid, instr_valid);
        end
      end
    end
    tests_run++;
    if (pc_ID !== rec_pc || instruction !== rec_instr) begin
      tests_failed++;
      $display("FAIL stall_stable: got %h/%h want %h/%h", pc_ID, instruction, rec_pc, rec_instr);
    end
    pops_before = pops;
    @(negedge clk);
    stall_ID = 1'b0;
    run_cycles(12);
    tests_run++;
    if (pops < pops_before + 5 || err_sum() != 0) begin
      tests_failed++;
      $display("FAIL stall_resume: got pops=%0d errs=%0d (pc %h exp %h) want >=%0d/0", pops, err_sum(), bad_pc, bad_exp, pops_before + 5);
    end
    $display("[TB] test_stall done");
  endtask

  task automatic test_ready_low();
    rsp_pct = 100;
    do_reset();
    #3;
    run_cycles(1);
    tests_run++;
    if (accepts != 2) begin tests_failed++; $display("FAIL ready_pre_accepts: got %0d want 2", accepts); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      #3;
      tests_run++;
      if (imem.imem_req_addr !== RST_PC + 32'd8 || (k == 2 && imem.imem_req_valid !== 1'b1)) begin
        tests_failed++;
        $display("FAIL ready_hold: cycle %0d got valid=%b addr=%h want addr %h", k, imem.imem_req_valid, imem.imem_req_addr, RST_PC + 32'd8);
      end
    end
    @(negedge clk);
    imem.imem_req_ready = 1'b1;
    #3;
    tests_run++;
    if (accepts != 3 || last_acc !== RST_PC + 32'd8) begin
      tests_failed++;
      $display("FAIL ready_accept: got accepts=%0d addr=%h want 3/%h", accepts, last_acc, RST_PC + 32'd8);
    end
    run_cycles(10);
    tests_run++;
    if (err_sum() != 0) begin
      tests_failed++;
      $display("FAIL ready_stream: got errs=%0d (pc %h exp %h) want 0", err_sum(), bad_pc, bad_exp);
    end
    $display("[TB] test_ready_low done");
  endtask

  task automatic test_redirect();
    bit found;
    rsp_pct = 100;
    do_reset();
    run_cycles(7);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #3;
    tests_run++;
    if (imem.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_req_off: got %b want 0", imem.imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    tests_run++;
    if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL redir_req: got valid=%b addr=%h want 1/00000100", imem.imem_req_valid, imem.imem_req_addr);
    end
    run_cycles(1);
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: got valid %b want 0", instr_valid); end
    run_cycles(1);
    tests_run++;
    if (instr_valid !== 1'b1 || pc_ID !== 32'h100 || instruction !== memf(32'h100)) begin
      tests_failed++;
      $display("FAIL redir_latency: got v=%b pc=%h i=%h want 1/00000100/%h", instr_valid, pc_ID, instruction, memf(32'h100));
    end
    // Starve responses so two requests are in flight when the next redirect lands.
    rsp_pct = 0;
    run_cycles(5);
    tests_run++;
    if (mem_q.size() != 2) begin tests_failed++; $display("FAIL redir_inflight: got %0d want 2", mem_q.size()); end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0180;
    #3;
    rsp_pct = 100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (instr_valid) found = 1;
      else run_cycles(1);
    end
    tests_run++;
    if (!found || pc_ID !== 32'h180) begin
      tests_failed++;
      $display("FAIL redir_drop2: got found=%0d pc=%h want 1/00000180", found, pc_ID);
    end
    run_cycles(8);
    tests_run++;
    if (err_sum() != 0) begin
      tests_failed++;
      $display("FAIL redir_stream: got errs=%0d (pc %h exp %h) want 0", err_sum(), bad_pc, bad_exp);
    end
    $display("[TB] test_redirect done");
  endtask

  task automatic test_redirect_rsp_stall();
    bit found;
    rsp_pct = 100;
    do_reset();
    #3;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (mem_q.size() > 0) found = 1;
      else run_cycles(1);
    end
    @(negedge clk);
    stall_ID       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #3;
    tests_run++;
    if (!found || imem.imem_rsp_valid !== 1'b1 || imem.imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsr_coincide: got rsp=%b req=%b want 1/0", imem.imem_rsp_valid, imem.imem_req_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    tests_run++;
    if (instr_valid !== 1'b0 || instruction !== NOP_INSTR) begin
      tests_failed++;
      $display("FAIL rsr_empty: got v=%b i=%h want 0/%h", instr_valid, instruction, NOP_INSTR);
    end
    run_cycles(3);
    @(negedge clk);
    stall_ID = 1'b0;
    #3;
    tests_run++;
    if (instr_valid !== 1'b1 || pc_ID !== 32'h200) begin
      tests_failed++;
      $display("FAIL rsr_next: got v=%b pc=%h want 1/00000200", instr_valid, pc_ID);
    end
    run_cycles(8);
    tests_run++;
    if (err_sum() != 0) begin
      tests_failed++;
      $display("FAIL rsr_stream: got errs=%0d (pc %h exp %h) want 0", err_sum(), bad_pc, bad_exp);
    end
    $display("[TB] test_redirect_rsp_stall done");
  endtask

  task automatic test_back_to_back();
    bit found;
    rsp_pct = 50;
    do_reset();
    run_cycles(6);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    #3;
    @(negedge clk);
    redirect_pc = 32'h0000_0400;
    #3;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (instr_valid) found = 1;
      else run_cycles(1);
    end
    tests_run++;
    if (!found || pc_ID !== 32'h400) begin
      tests_failed++;
      $display("FAIL b2b_last_wins: got found=%0d pc=%h want 1/00000400", found, pc_ID);
    end
    run_cycles(20);
    tests_run++;
    if (err_sum() != 0) begin
      tests_failed++;
      $display("FAIL b2b_stream: got errs=%0d (pc %h exp %h) want 0", err_sum(), bad_pc, bad_exp);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_async_reset();
    rsp_pct = 100;
    do_reset();
    run_cycles(9);
    reset = 1'b1;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || instruction !== NOP_INSTR || pc_ID !== RST_PC ||
        imem.imem_req_valid !== 1'b0 || imem.imem_req_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b i=%h pc=%h rv=%b ra=%h want 0/%h/%h/0/%h",
               instr_valid, instruction, pc_ID, imem.imem_req_valid, imem.imem_req_addr, NOP_INSTR, RST_PC, RST_PC);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    tests_run++;
    if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL async_restart: got valid=%b addr=%h want 1/%h", imem.imem_req_valid, imem.imem_req_addr, RST_PC);
    end
    run_cycles(10);
    tests_run++;
    if (pops < 4 || err_sum() != 0) begin
      tests_failed++;
      $display("FAIL async_stream: got pops=%0d errs=%0d want >=4/0", pops, err_sum());
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    int redirects = 0;
    rsp_pct = 60;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      imem.imem_req_ready = ($urandom_range(99) < 70);
      stall_ID            = ($urandom_range(99) < 30);
      redirect_valid      = ($urandom_range(99) < 4);
      if (redirect_valid) begin
        redirects++;
        redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      end
      #3;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    stall_ID       = 1'b0;
    #3;
    tests_run++;
    if (pops < 200 || err_sum() != 0) begin
      tests_failed++;
      $display("FAIL random_stream: got pops=%0d errs stream=%0d seq=%0d hold=%0d out=%0d stall=%0d nop=%0d (pc %h exp %h) want >=200/0",
               pops, err_stream, err_seq, err_hold, err_out, err_stall, err_nop, bad_pc, bad_exp);
    end
    $display("[TB] test_random done, %0d instructions, %0d redirects", pops, redirects);
  endtask

  initial begin
    reset               = 1'b1;
    stall_ID            = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    imem.imem_req_ready = 1'b1;
    test_reset();
    test_first_fetch();
    test_stall();
    test_ready_low();
    test_redirect();
    test_redirect_rsp_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
